mesh_term_tx: RTL and testbench
===============================

// Module: mesh_term_tx
// PURPOSE
//  Terminal-side packet injector for one mesh_gnrtr edge port.
//  - Accepts packet fields from local logic, validates the destination, assembles a
//    pckg_sz-bit packet and queues it in a FIFO.
//  - Presents the FIFO head to the router on data_out_i_in/pndng_i_in and advances on
//    the router's popin.
//  - Synthesizable replacement for the bench-side driver of one terminal.
// PARAMETERS
//  pckg_sz     40  packet width in bits (>= 24)
//  fifo_depth   4  queue entries (power of 2, >= 2)
//  ROWS         4  mesh rows
//  COLUMS       4  mesh columns
//  CNT_W       16  width of tx_count
// PORTS
//  clk            in   1             system clock, rising edge
//  reset          in   1             synchronous, active-high
//  wr_en          in   1             local write strobe
//  wr_row         in   4             destination terminal row
//  wr_col         in   4             destination terminal column
//  wr_mode        in   1             routing mode bit (1: row-first, 0: column-first)
//  wr_payload     in   pckg_sz-17    payload
//  full           out  1             queue full; write this cycle is dropped
//  data_out_i_in  out  pckg_sz       packet at queue head, to router
//  pndng_i_in     out  1             queue not empty, to router
//  popin          in   1             router consumed head this cycle
//  err_addr       out  1             1-cycle pulse: write rejected, illegal destination
//  ovf            out  1             sticky: write attempted while full
//  udf            out  1             sticky: popin while empty
//  tx_count       out  CNT_W         packets accepted by router (wraps)
// BEHAVIOUR
//  Packet layout:
//    [pckg_sz-1:pckg_sz-8]     Nxt_jump = 8'h00
//    [pckg_sz-9:pckg_sz-12]    wr_row
//    [pckg_sz-13:pckg_sz-16]   wr_col
//    [pckg_sz-17]              wr_mode
//    [pckg_sz-18:0]            wr_payload
//  Legal destination (edge terminals only):
//    - row==0 or row==ROWS+1, with col in 1..COLUMS
//    - or col==0 or col==COLUMS+1, with row in 1..ROWS
//    - Corners and interior coordinates are illegal: no enqueue, err_addr=1 next cycle.
//  Reset (synchronous, while reset==1 at posedge):
//    - rd_ptr=wr_ptr=count=0; pndng_i_in=0; data_out_i_in=0; full=0.
//    - err_addr=0; ovf=0; udf=0; tx_count=0.
//    - Reset mid-traffic discards all queued packets; popin is ignored during reset.
//  Enqueue:
//    - Legal wr_en && !full at posedge writes entry wr_ptr; wr_ptr wraps mod fifo_depth.
//    - Packet is visible on data_out_i_in one cycle later if the queue was empty
//      (write-to-pndng latency = 1).
//  Dequeue:
//    - pndng_i_in = (count!=0).
//    - data_out_i_in = mem[rd_ptr], combinational from registered state; 0 when empty.
//    - popin && pndng_i_in at posedge: rd_ptr++ (wrap), tx_count++ (wrap at 2^CNT_W).
//    - Next entry is shown the following cycle; back-to-back pops sustain 1 pkt/cycle.
//  Simultaneous events:
//    - Write+pop with 0<count<depth: count unchanged, both pointers advance.
//    - Write+pop when full: pop frees a slot and the write is ACCEPTED; full is
//      combinational (count==depth && !popin).
//    - Write+pop when empty: pop is ignored (udf=1), write is accepted.
//    - Write while full without popin: dropped, ovf=1 (sticky until reset).
//  Error precedence:
//    - Illegal address checked first: err_addr pulses and ovf is not set, even if full.
//  FIFO state counter: 0..fifo_depth inclusive (clog2(depth)+1 bits); never over/underflows.
// TESTING
//  T1 reset 5 cycles, write row=0 col=1 mode=1 payload=1 -> next cycle pndng=1,
//     data_out_i_in=40'h00_0_1_800001; popin 1 cycle -> pndng=0, tx_count=1.
//  T2 write row=2 col=2 (interior) and row=0 col=0 (corner) -> err_addr pulses twice,
//     pndng stays 0, tx_count=0.
//  T3 4 legal writes with no pop -> full=1; 5th write -> dropped, ovf=1; pop 4 ->
//     payloads in order 1,2,3,4.
//  T4 queue full plus write+popin same cycle -> write accepted, count stays 4,
//     ovf stays 0; popin on empty queue -> udf=1, tx_count unchanged.
//  T5 continuous writes+pops for 20 cycles -> 1 pkt/cycle, in-order payloads, tx_count=20;
//     assert reset mid-stream with 3 queued -> pndng=0 next cycle, tx_count=0.

Source files
------------

// File: rtl/mesh_term_tx.sv
// Terminal-side packet injector for one mesh edge port: validates the destination,
// assembles a packet, queues it and presents the queue head to the router.
module mesh_term_tx #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [3:0]         wr_row,
    input  logic [3:0]         wr_col,
    input  logic               wr_mode,
    input  logic [pckg_sz-18:0] wr_payload,
    output logic               full,
    output logic [pckg_sz-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    output logic               err_addr,
    output logic               ovf,
    output logic               udf,
    output logic [CNT_W-1:0]   tx_count
);

    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);

    // Only edge terminals are reachable; corners and interior nodes are not.
    function automatic logic addr_legal(input logic [3:0] r, input logic [3:0] c);
        logic row_edge;
        logic col_edge;
        logic row_in;
        logic col_in;
        row_edge = (r == 4'd0) || (int'(r) == ROWS + 1);
        col_edge = (c == 4'd0) || (int'(c) == COLUMS + 1);
        row_in   = (r != 4'd0) && (int'(r) <= ROWS);
        col_in   = (c != 4'd0) && (int'(c) <= COLUMS);
        return (row_edge && col_in) || (col_edge && row_in);
    endfunction

    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [pckg_sz-1:0] mem_d [fifo_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               err_addr_q, err_addr_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;

    logic               legal;
    logic               wr_accept;
    logic               pop;
    logic [pckg_sz-1:0] pkt;

    always_comb begin
        full          = (count_q == DEPTH_C) && !popin;
        pndng_i_in    = (count_q != '0);
        data_out_i_in = pndng_i_in ? mem_q[rd_ptr_q] : '0;

        legal     = addr_legal(wr_row, wr_col);
        wr_accept = wr_en && legal && !full;
        pop       = popin && pndng_i_in;
        pkt       = {8'h00, wr_row, wr_col, wr_mode, wr_payload};

        mem_d = mem_q;
        if (wr_accept) begin
            mem_d[wr_ptr_q] = pkt;
        end

        wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Address check wins over the full check, so a bad address never sets ovf.
        err_addr_d = wr_en && !legal;
        ovf_d      = ovf_q | (wr_en && legal && full);
        udf_d      = udf_q | (popin && !pndng_i_in);
        tx_count_d = pop ? tx_count_q + 1'b1 : tx_count_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_addr_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            tx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_addr_q <= err_addr_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign err_addr = err_addr_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Directed bench for mesh_term_tx with hand-computed packets and a single check task.
module tb_mesh_term_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic        wr_mode;
    logic [22:0] wr_payload;
    logic        full;
    logic [39:0] data_out_i_in;
    logic        pndng_i_in;
    logic        popin;
    logic        err_addr;
    logic        ovf;
    logic        udf;
    logic [15:0] tx_count;

    int checks = 0;
    int errors = 0;

    mesh_term_tx #(.pckg_sz(40), .fifo_depth(4), .ROWS(4), .COLUMS(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_mode(wr_mode), .wr_payload(wr_payload), .full(full),
        .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
        .err_addr(err_addr), .ovf(ovf), .udf(udf), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [3:0] r, input logic [3:0] c,
                          input logic m, input logic [22:0] p);
        wr_en = en; wr_row = r; wr_col = c; wr_mode = m; wr_payload = p;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; popin = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Packet for the default test destination row 0, col 1, mode 0.
    function automatic logic [39:0] pk(input logic [22:0] p);
        return {8'h00, 4'd0, 4'd1, 1'b0, p};
    endfunction

    initial begin
        reset = 1'b1; popin = 1'b0;
        set_wr(1'b0, 4'd0, 4'd0, 1'b0, 23'd0);
        repeat (5) tick();
        chk("rst_pndng", 64'(pndng_i_in), 64'(0));
        chk("rst_data",  64'(data_out_i_in), 64'(0));
        chk("rst_full",  64'(full), 64'(0));
        chk("rst_err",   64'(err_addr), 64'(0));
        chk("rst_ovf",   64'(ovf), 64'(0));
        chk("rst_udf",   64'(udf), 64'(0));
        chk("rst_tx",    64'(tx_count), 64'(0));
        reset = 1'b0;

        // T1: single packet round trip
        set_wr(1'b1, 4'd0, 4'd1, 1'b1, 23'd1);
        tick();
        wr_en = 1'b0;
        chk("t1_pndng", 64'(pndng_i_in), 64'(1));
        chk("t1_data",  64'(data_out_i_in), 64'h00_0_1_800001);
        popin = 1'b1;
        tick();
        popin = 1'b0;
        chk("t1_pndng_after", 64'(pndng_i_in), 64'(0));
        chk("t1_tx", 64'(tx_count), 64'(1));

        // T2: illegal destinations, then legal far-edge destinations
        do_reset();
        set_wr(1'b1, 4'd2, 4'd2, 1'b0, 23'd5);
        tick();
        chk("t2_err_interior", 64'(err_addr), 64'(1));
        set_wr(1'b1, 4'd0, 4'd0, 1'b0, 23'd5);
        tick();
        chk("t2_err_corner", 64'(err_addr), 64'(1));
        chk("t2_pndng", 64'(pndng_i_in), 64'(0));
        set_wr(1'b1, 4'd5, 4'd5, 1'b0, 23'd5);
        tick();
        chk("t2_err_far_corner", 64'(err_addr), 64'(1));
        set_wr(1'b1, 4'd0, 4'd5, 1'b0, 23'd5);
        tick();
        chk("t2_err_col_oob", 64'(err_addr), 64'(1));
        chk("t2_tx", 64'(tx_count), 64'(0));
        set_wr(1'b1, 4'd5, 4'd4, 1'b0, 23'h7FFFFF);
        tick();
        chk("t2_err_legal", 64'(err_addr), 64'(0));
        chk("t2_data_legal", 64'(data_out_i_in), 64'h00_5_4_7FFFFF);
        set_wr(1'b1, 4'd4, 4'd0, 1'b1, 23'd3);
        tick();
        wr_en = 1'b0;
        chk("t2_err_legal2", 64'(err_addr), 64'(0));
        popin = 1'b1;
        tick();
        chk("t2_data_second", 64'(data_out_i_in), 64'h00_4_0_800003);
        popin = 1'b0;

        // T3: fill, overflow, drain in order
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'(i));
            tick();
        end
        chk("t3_full", 64'(full), 64'(1));
        set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'd5);
        tick();
        wr_en = 1'b0;
        chk("t3_ovf", 64'(ovf), 64'(1));
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t3_pop%0d", i), 64'(data_out_i_in), 64'(pk(23'(i))));
            popin = 1'b1;
            tick();
        end
        popin = 1'b0;
        chk("t3_empty", 64'(pndng_i_in), 64'(0));
        chk("t3_tx", 64'(tx_count), 64'(4));

        // T4: write+pop on full, address precedence, underflow, write+pop on empty
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'(i));
            tick();
        end
        set_wr(1'b1, 4'd2, 4'd2, 1'b0, 23'd0);
        tick();
        chk("t4_err_full", 64'(err_addr), 64'(1));
        chk("t4_ovf_prec", 64'(ovf), 64'(0));
        set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'd9);
        popin = 1'b1;
        #1;
        chk("t4_full_popin", 64'(full), 64'(0));
        tick();
        wr_en = 1'b0; popin = 1'b0;
        #1;
        chk("t4_ovf", 64'(ovf), 64'(0));
        chk("t4_still_full", 64'(full), 64'(1));
        chk("t4_head", 64'(data_out_i_in), 64'(pk(23'd2)));
        popin = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_drained", 64'(pndng_i_in), 64'(0));
        chk("t4_tx_drain", 64'(tx_count), 64'(5));
        tick();
        chk("t4_udf", 64'(udf), 64'(1));
        chk("t4_tx_udf", 64'(tx_count), 64'(5));
        set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'd7);
        tick();
        wr_en = 1'b0; popin = 1'b0;
        chk("t4_wr_empty_pop", 64'(data_out_i_in), 64'(pk(23'd7)));
        chk("t4_tx_empty_pop", 64'(tx_count), 64'(5));

        // T5: streaming at one packet per cycle, then reset with traffic queued
        do_reset();
        set_wr(1'b1, 4'd0, 4'd1, 1'b0, 23'd1);
        tick();
        popin = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_payload = 23'(k + 2);
            chk($sformatf("t5_stream%0d", k), 64'(data_out_i_in), 64'(pk(23'(k + 1))));
            tick();
        end
        popin = 1'b0;
        chk("t5_tx", 64'(tx_count), 64'(20));
        for (int k = 0; k < 2; k++) begin
            wr_payload = 23'(k + 30);
            tick();
        end
        wr_en = 1'b0;
        chk("t5_head_queued", 64'(data_out_i_in), 64'(pk(23'd21)));
        reset = 1'b1; popin = 1'b1;
        tick();
        chk("t5_rst_pndng", 64'(pndng_i_in), 64'(0));
        chk("t5_rst_tx", 64'(tx_count), 64'(0));
        chk("t5_rst_data", 64'(data_out_i_in), 64'(0));
        reset = 1'b0; popin = 1'b0;
        tick();
        chk("t5_post_pndng", 64'(pndng_i_in), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
